// File: rtl/core_bus_arbiter_pkg.sv
// Shared core bus definitions: widths, master ids, arbiter states.
// Reused by the arbiter, the top-level address mux and later masters.
package core_bus_arbiter_pkg;

   localparam int CB_ADDR_W = 16;
   localparam int CB_DATA_W = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } arb_state_e;

endpackage

// File: rtl/core_bus_arbiter.sv
// Two-master core bus arbiter: round-robin with burst allowance,
// one access per grant, registered read data/error per master.
// Ports: clk, reset_n; m0_*/m1_* request side (req, we, address,
// write_data in; ack, read_data, error out); core_* bus side
// (cs, we, address, write_data out; read_data, error in); busy.
module core_bus_arbiter
   import core_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = CB_ADDR_W,
   parameter int DATA_WIDTH = CB_DATA_W,
   parameter int MAX_BURST  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [DATA_WIDTH-1:0] m0_write_data,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_read_data,
   output logic                  m0_error,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [DATA_WIDTH-1:0] m1_write_data,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_read_data,
   output logic                  m1_error,
   output logic                  core_cs,
   output logic                  core_we,
   output logic [ADDR_WIDTH-1:0] core_address,
   output logic [DATA_WIDTH-1:0] core_write_data,
   input  logic [DATA_WIDTH-1:0] core_read_data,
   input  logic                  core_error,
   output logic                  busy
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_q, last_d;
   logic [BW-1:0]         burst_q, burst_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] m0_rd_q, m1_rd_q;
   logic                  m0_err_q, m1_err_q;
   logic                  both, pick;

   // A zero burst count means no contested run is in progress,
   // so a tie goes to the other master (m0 first after reset).
   always_comb begin
      both = m0_req & m1_req;
      pick = M0;
      if (both) begin
         if (burst_q != '0 && burst_q < BURST_MAX)
            pick = last_q;
         else
            pick = ~last_q;
      end else if (m1_req) begin
         pick = M1;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      burst_d = burst_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (m0_req | m1_req) begin
               state_d = ST_ACCESS;
               grant_d = pick;
               last_d  = pick;
               we_d    = pick ? m1_we : m0_we;
               addr_d  = pick ? m1_address : m0_address;
               wdata_d = pick ? m1_write_data : m0_write_data;
               if (!both)
                  burst_d = '0;
               else if (pick != last_q)
                  burst_d = BW'(1);
               else if (burst_q != BURST_MAX)
                  burst_d = burst_q + BW'(1);
            end
         end
         ST_ACCESS: state_d = ST_ACK;
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= M0;
         last_q   <= M1;
         burst_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         m0_rd_q  <= '0;
         m1_rd_q  <= '0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (state_q == ST_ACCESS) begin
            if (grant_q == M0) begin
               if (!we_q) m0_rd_q <= core_read_data;
               m0_err_q <= core_error;
            end else begin
               if (!we_q) m1_rd_q <= core_read_data;
               m1_err_q <= core_error;
            end
         end
      end
   end

   // Bus fields are gated so the mux never sees a stale access.
   assign core_cs         = (state_q == ST_ACCESS);
   assign core_we         = core_cs & we_q;
   assign core_address    = core_cs ? addr_q : '0;
   assign core_write_data = core_cs ? wdata_q : '0;

   assign m0_ack       = (state_q == ST_ACK) && (grant_q == M0);
   assign m1_ack       = (state_q == ST_ACK) && (grant_q == M1);
   assign m0_read_data = m0_rd_q;
   assign m1_read_data = m1_rd_q;
   assign m0_error     = m0_err_q;
   assign m1_error     = m1_err_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: two random masters,
// a behavioural slave and a transaction-level arbitration model.
module tb_core_bus_arbiter;

   localparam int MB = 3;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [15:0] m0_address = 0, m1_address = 0;
   logic [31:0] m0_write_data = 0, m1_write_data = 0;
   logic        m0_ack, m1_ack, m0_error, m1_error;
   logic [31:0] m0_read_data, m1_read_data;
   logic        core_cs, core_we, core_error, busy;
   logic [15:0] core_address;
   logic [31:0] core_write_data, core_read_data;

   int tests = 0;
   int fails = 0;
   txn_t q0[$];
   txn_t q1[$];
   int glog[$];
   logic [31:0] last_rd [2];

   core_bus_arbiter #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address),
      .m0_write_data(m0_write_data), .m0_ack(m0_ack),
      .m0_read_data(m0_read_data), .m0_error(m0_error),
      .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address),
      .m1_write_data(m1_write_data), .m1_ack(m1_ack),
      .m1_read_data(m1_read_data), .m1_error(m1_error),
      .core_cs(core_cs), .core_we(core_we),
      .core_address(core_address),
      .core_write_data(core_write_data),
      .core_read_data(core_read_data), .core_error(core_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] slave_rd(input logic [15:0] a);
      if (a == 16'h1020) return 32'hDEADBEEF;
      return {a ^ 16'h5A5A, ~a};
   endfunction

   always_comb begin
      core_read_data = slave_rd(core_address);
      core_error = core_cs && !core_we && (core_address == 16'h2000);
   end

   task automatic chk(input logic [31:0] act, input logic [31:0] exp,
                      input string nm);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int m, input logic r, input logic w,
                        input logic [15:0] a, input logic [31:0] d);
      if (m == 0) begin
         m0_req = r; m0_we = w; m0_address = a; m0_write_data = d;
      end else begin
         m1_req = r; m1_we = w; m1_address = a; m1_write_data = d;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the ack cycle.
   task automatic issue(input int m, input logic w,
                        input logic [15:0] a, input logic [31:0] d);
      txn_t t;
      bit   got;
      t.we = w; t.addr = a; t.wdata = d;
      if (!w) last_rd[m] = slave_rd(a);
      t.rdata = last_rd[m];
      t.err = !w && (a == 16'h2000);
      if (m == 0) q0.push_back(t); else q1.push_back(t);
      drive(m, 1'b1, w, a, d);
      got = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if ((m == 0) ? m0_ack : m1_ack) begin
            got = 1;
            break;
         end
      end
      chk(32'(got), 32'd1, $sformatf("ack_timeout_m%0d", m));
   endtask

   task automatic run_master(input int m, input int n, input int maxgap);
      for (int i = 0; i < n; i++) begin
         int gap;
         logic [15:0] a;
         gap = $urandom_range(maxgap, 0);
         if (gap > 0) begin
            drive(m, 1'b0, 1'b0, 16'h0, 32'h0);
            repeat (gap) begin @(posedge clk); #1; end
         end
         case ($urandom_range(2, 0))
            0: a = 16'h1020;
            1: a = 16'h2000;
            default: a = 16'($urandom);
         endcase
         issue(m, 1'($urandom), a, $urandom);
      end
      drive(m, 1'b0, 1'b0, 16'h0, 32'h0);
   endtask

   // Transaction-level model: a granted access occupies the cycle
   // after an idle cycle with a request (bus), then one ack cycle.
   int   mon_phase, mon_np, mon_g, mon_last, mon_streak;
   logic [1:0] mon_prev;
   bit   mon_ecs;
   txn_t mon_t;

   always @(negedge clk) begin
      if (!reset_n) begin
         mon_phase = 0; mon_prev = 2'b00; mon_last = 1;
         mon_streak = 0; q0.delete(); q1.delete();
      end else begin
         mon_ecs = (mon_phase == 0) && (mon_prev != 2'b00);
         if (mon_ecs) begin
            if (mon_prev == 2'b01) mon_g = 0;
            else if (mon_prev == 2'b10) mon_g = 1;
            else if (mon_streak > 0 && mon_streak < MB) mon_g = mon_last;
            else mon_g = 1 - mon_last;
            if (mon_prev != 2'b11) mon_streak = 0;
            else if (mon_g != mon_last) mon_streak = 1;
            else if (mon_streak < MB) mon_streak++;
            mon_last = mon_g;
            glog.push_back(mon_g);
         end
         mon_np = mon_ecs ? 1 : ((mon_phase == 1) ? 2 : 0);
         chk(32'(core_cs), 32'(mon_ecs), "cs_timing");
         chk(32'(busy), 32'(mon_np != 0), "busy");
         if (mon_ecs) begin
            if ((mon_g == 0 ? q0.size() : q1.size()) == 0) begin
               chk(32'd0, 32'd1, "grant_without_pending_txn");
            end else begin
               mon_t = (mon_g == 0) ? q0[0] : q1[0];
               chk(32'(core_we), 32'(mon_t.we), "core_we");
               chk(32'(core_address), 32'(mon_t.addr), "core_address");
               chk(core_write_data, mon_t.wdata, "core_write_data");
            end
         end else begin
            chk({15'd0, core_we, core_address}, 32'd0, "idle_bus_fields");
            chk(core_write_data, 32'd0, "idle_bus_wdata");
         end
         if (mon_np == 2) begin
            if ((mon_g == 0 ? q0.size() : q1.size()) == 0) begin
               chk(32'd0, 32'd1, "ack_without_pending_txn");
            end else begin
               mon_t = (mon_g == 0) ? q0.pop_front() : q1.pop_front();
               chk(32'({m1_ack, m0_ack}), (mon_g == 0) ? 32'd1 : 32'd2,
                   "ack_master");
               chk((mon_g == 0) ? m0_read_data : m1_read_data,
                   mon_t.rdata, "read_data");
               chk(32'((mon_g == 0) ? m0_error : m1_error),
                   32'(mon_t.err), "error");
            end
         end else begin
            chk(32'({m1_ack, m0_ack}), 32'd0, "no_ack");
         end
         mon_phase = mon_np;
         mon_prev = {m1_req, m0_req};
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      last_rd[0] = 0;
      last_rd[1] = 0;
      #22 reset_n = 1'b1;
      @(negedge clk);
      chk(32'({core_cs, busy, m0_ack, m1_ack}), 32'd0, "reset_ctrl");
      chk(m0_read_data, 32'd0, "reset_m0_rd");
      chk(m1_read_data, 32'd0, "reset_m1_rd");
      chk(32'({m0_error, m1_error}), 32'd0, "reset_err");
      @(posedge clk); #1;

      issue(0, 1'b0, 16'h1020, 32'h0);
      drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
      chk(m0_read_data, 32'hDEADBEEF, "m0_read_1020");
      @(posedge clk); #1;
      issue(1, 1'b1, 16'h0008, 32'h0000_00A5);
      drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
      chk(m0_read_data, 32'hDEADBEEF, "m0_rd_kept_on_m1");
      chk(32'(m0_error), 32'd0, "m0_err_kept_on_m1");
      @(posedge clk); #1;
      issue(0, 1'b0, 16'h2000, 32'h0);
      chk(32'(m0_error), 32'd1, "m0_err_set");
      issue(0, 1'b0, 16'h1020, 32'h0);
      drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
      chk(32'(m0_error), 32'd0, "m0_err_cleared");

      fork
         run_master(0, 30, 3);
         run_master(1, 30, 3);
      join
      repeat (3) begin @(posedge clk); #1; end

      drive(0, 1'b1, 1'b0, 16'h1020, 32'h0);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk(32'({core_cs, m0_ack, m1_ack}), 32'd0, "abort_cs_ack");
      chk(32'(busy), 32'd0, "abort_busy");
      chk(m0_read_data, 32'd0, "abort_rd_cleared");
      drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
      last_rd[0] = 0;
      last_rd[1] = 0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      chk(32'({m0_ack, m1_ack, core_cs}), 32'd0, "no_late_ack");

      glog.delete();
      fork
         run_master(0, 6, 0);
         run_master(1, 6, 0);
      join
      repeat (2) begin @(posedge clk); #1; end
      chk(32'(glog.size()), 32'd12, "burst_grant_count");
      for (int i = 0; i < 12 && i < glog.size(); i++)
         chk(32'(glog[i]), 32'((i / MB) % 2),
             $sformatf("burst_grant_%0d", i));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
